hc595_frame_serializer: RTL and testbench
=========================================

Name: hc595_frame_serializer

Overview:
- Downstream stage of the 7-segment encoder. Accepts one parallel frame (segment byte plus digit-select byte per 74HC595 in the chain) through a valid/ready handshake.
- Shifts the frame MSB-first into the daisy-chained 74HC595s, then pulses the storage latch.
- Replaces free-running trigger-tied serialization: the producer learns exactly when a frame is on the display, and SCLK speed is set by parameter.

Parameters:
- NUM_ICS, 2, number of chained 74HC595s; frame width W = 8*NUM_ICS.
- SCLK_DIV, 1, clk_i cycles per SCLK half-period (D). Legal range 1..255; 0 is illegal and flagged by a simulation assertion.

Ports:
- clk_i  input  1  system clock (8.192 kHz on the clock board).
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  producer has a frame on data_i.
- ready_o  input/output: output  1  block idle, can accept a frame.
- data_i  input  W  frame; bit W-1 shifted first, bit 0 ends in the nearest 595 output.
- sclk_o  output  1  595 SRCLK.
- data_o  output  1  595 SER.
- latch_o  output  1  595 RCLK (storage latch).
- busy_o  output  1  frame in progress (= !ready_o).

Behaviour:
- Reset (async assert, sync release): state IDLE. sclk_o=0, data_o=0, latch_o=0, ready_o=1, busy_o=0. Shift register and counters are cleared.
- States are IDLE, SHIFT_LO, SHIFT_HI and LATCH. ready_o = (state==IDLE). All serial outputs are registered.
- Acceptance happens at a rising edge where valid_i && ready_o. Call it edge 0. data_i is captured into an internal W-bit shift register. Bit counter = W-1, divider = 0, state goes to SHIFT_LO.
- Cycle n denotes the interval after edge n. Frame timing:
  - Bit j (j=0 is data_i[W-1]) low phase: cycles 1+2Dj .. D+2Dj. During it sclk_o=0 and data_o = that bit, stable for the whole low and high phase.
  - Bit j high phase: cycles D+1+2Dj .. 2D+2Dj. sclk_o=1, so the 595 samples on the sclk_o rising edge.
  - After the last bit's high phase: LATCH for cycles 1+2DW .. 2DW+D, with latch_o=1, sclk_o=0, data_o held at the last bit.
  - Cycle 2DW+D+1: back to IDLE, ready_o=1, latch_o=0.
  - Minimum frame period is 2DW+D+1 cycles. Back-to-back acceptance on the first IDLE cycle is allowed.
- data_o changes only on the transition into SHIFT_LO, never while sclk_o=1 or latch_o=1.
- SHIFT_HI to SHIFT_LO when the divider expires and the bit counter is not 0. The counter decrements and the register shifts left by one. At counter 0, go to LATCH.
- Divider: ceil(log2(SCLK_DIV+1)) bits. It counts 0..D-1 in each phase and resets on every state change.
- Bit counter: ceil(log2(W)) bits. No wrap; it stops at 0.
- valid_i while busy is ignored. No buffering; the producer holds valid_i until ready_o. data_i is don't-care except at acceptance.
- valid_i held high continuously produces continuous frames with the period above.
- rst_ni asserted mid-frame: outputs drop to 0 immediately, latch_o is never pulsed, and the 595 storage keeps the previous display. After release, ready_o=1 on the first cycle.
- No combinational path from valid_i or data_i to any output.

Test Plan:
- Reset: rst_ni=0 with random inputs -> sclk_o=data_o=latch_o=0, ready_o=1. Release with valid_i=0 -> outputs stay idle for 100 cycles.
- Single frame, NUM_ICS=2, D=1, data_i=16'hA5C3 accepted at edge 0 -> 16 sclk_o rising edges at cycles 2,4,...,32. Bits sampled 1010_0101_1100_0011. latch_o=1 only in cycle 33. ready_o=1 in cycle 34. Model 595 parallel output = 16'hA5C3.
- Divider, D=3, data_i=16'h0001 -> sclk_o high for 3 cycles and low for 3 cycles. latch_o high cycles 97..99. ready_o at cycle 100. Only the final rising edge samples data_o=1.
- Backpressure: valid_i held with 16'h1234 then 16'hFFFF -> second acceptance exactly at cycle 34. Data changes during busy are ignored. Displays show 1234 then FFFF.
- Mid-frame reset: assert rst_ni=0 in cycle 10 of a frame -> outputs 0 asynchronously. No latch pulse. Model 595 storage unchanged from the prior frame. A new frame after release completes normally.
- Stability check: across random frames, data_o never toggles while sclk_o=1 or latch_o=1, and latch_o never overlaps sclk_o=1.

Source files
------------

// File: rtl/hc595_frame_serializer.sv
// hc595_frame_serializer
// Takes one parallel frame through a valid/ready handshake. It shifts the frame
// MSB-first into a chain of 74HC595s, then pulses the storage latch once.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   valid_i  producer offers a frame on data_i
//   ready_o  idle, a frame can be accepted this cycle
//   data_i   frame, bit W-1 is shifted out first
//   sclk_o   595 SRCLK
//   data_o   595 SER
//   latch_o  595 RCLK
//   busy_o   frame in progress (inverse of ready_o)
module hc595_frame_serializer #(
  parameter int unsigned NUM_ICS  = 2,
  parameter int unsigned SCLK_DIV = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [8*NUM_ICS-1:0]   data_i,
  output logic                   sclk_o,
  output logic                   data_o,
  output logic                   latch_o,
  output logic                   busy_o
);

  localparam int unsigned W       = 8 * NUM_ICS;
  localparam int unsigned DIV_W   = (SCLK_DIV < 1) ? 1 : $clog2(SCLK_DIV + 1);
  localparam int unsigned CNT_W   = $clog2(W);
  localparam int unsigned DIV_MAX = (SCLK_DIV < 1) ? 0 : SCLK_DIV - 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_MAX);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFT_LO = 2'd1,
    S_SHIFT_HI = 2'd2,
    S_LATCH    = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_shreg;
  logic             r_sclk;
  logic             r_latch;
  logic             r_ready;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [W-1:0]     w_shreg_nxt;
  logic             w_div_done;

  // Divider period must fit the 1..255 range.
  always_ff @(posedge clk_i) begin
    assert (SCLK_DIV >= 1 && SCLK_DIV <= 255)
      else $error("hc595_frame_serializer: SCLK_DIV=%0d out of range 1..255", SCLK_DIV);
  end

  assign w_div_done = (r_div == DIV_LAST);

  // Next-state, divider, bit counter and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    unique case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_state_nxt = S_SHIFT_LO;
          w_shreg_nxt = data_i;
          w_cnt_nxt   = CNT_FIRST;
          w_div_nxt   = '0;
        end
      end
      S_SHIFT_LO: begin
        if (w_div_done) begin
          w_state_nxt = S_SHIFT_HI;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (w_div_done) begin
          w_div_nxt = '0;
          if (r_cnt != '0) begin
            // Next bit appears on SER together with the SRCLK falling edge.
            w_state_nxt = S_SHIFT_LO;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_shreg_nxt = {r_shreg[W-2:0], 1'b0};
          end else begin
            w_state_nxt = S_LATCH;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (w_div_done) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
      end
    endcase
  end

  // State register; serial outputs are decoded from the next state so they are flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_sclk  <= (w_state_nxt == S_SHIFT_HI);
      r_latch <= (w_state_nxt == S_LATCH);
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // SER is the MSB of the shift register and holds the last bit through LATCH/IDLE.
  assign data_o  = r_shreg[W-1];
  assign sclk_o  = r_sclk;
  assign latch_o = r_latch;
  assign ready_o = r_ready;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_hc595_frame_serializer.sv
// Testbench for hc595_frame_serializer: one instance with SCLK_DIV=1 (index 0)
// and one with SCLK_DIV=3 (index 1), each driving a behavioural 595 chain model.
module tb_hc595_frame_serializer;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic [1:0]     rst_n;
  logic [1:0]     valid;
  logic [W-1:0]   din [2];
  logic [1:0]     sclk;
  logic [1:0]     sdo;
  logic [1:0]     lat;
  logic [1:0]     rdy;
  logic [1:0]     bsy;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hc595_frame_serializer #(.NUM_ICS(2), .SCLK_DIV(1)) u_d1 (
    .clk_i   (clk),
    .rst_ni  (rst_n[0]),
    .valid_i (valid[0]),
    .ready_o (rdy[0]),
    .data_i  (din[0]),
    .sclk_o  (sclk[0]),
    .data_o  (sdo[0]),
    .latch_o (lat[0]),
    .busy_o  (bsy[0])
  );

  hc595_frame_serializer #(.NUM_ICS(2), .SCLK_DIV(3)) u_d3 (
    .clk_i   (clk),
    .rst_ni  (rst_n[1]),
    .valid_i (valid[1]),
    .ready_o (rdy[1]),
    .data_i  (din[1]),
    .sclk_o  (sclk[1]),
    .data_o  (sdo[1]),
    .latch_o (lat[1]),
    .busy_o  (bsy[1])
  );

  // Behavioural 595 chain: shift on SRCLK rise, copy to storage on RCLK rise.
  logic [1:0]   p_sclk;
  logic [1:0]   p_lat;
  logic [W-1:0] sh595 [2];
  logic [W-1:0] disp  [2];
  int           rises [2] = '{0, 0};
  int           ones  [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk[i] === 1'b1 && p_sclk[i] !== 1'b1) begin
        sh595[i] = {sh595[i][W-2:0], sdo[i]};
        rises[i] = rises[i] + 1;
        if (sdo[i] === 1'b1) ones[i] = ones[i] + 1;
      end
      if (lat[i] === 1'b1 && p_lat[i] !== 1'b1) disp[i] = sh595[i];
      p_sclk[i] = sclk[i];
      p_lat[i]  = lat[i];
    end
  end

  // Observed output vector {sclk, data, latch, ready, busy}.
  function automatic logic [4:0] obs(input int s);
    return {sclk[s], sdo[s], lat[s], rdy[s], bsy[s]};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Offer frame f to instance s and check every cycle until the first idle cycle.
  // hold keeps valid high (data randomised while busy, nxt presented on the idle cycle).
  // abort_at > 0 asserts reset at that cycle and returns.
  task automatic frame(input int s, input logic [W-1:0] f, input bit hold,
                       input logic [W-1:0] nxt, input int abort_at);
    int         d;
    int         last;
    int         j;
    bit         hi;
    logic [4:0] e;
    logic [4:0] o;
    logic [4:0] p;
    d    = (s == 0) ? 1 : 3;
    last = 2 * d * int'(W) + d + 1;
    p    = '0;
    check($sformatf("ready_before_accept_s%0d", s), 32'(rdy[s]), 32'd1);
    valid[s] = 1'b1;
    din[s]   = f;
    @(posedge clk);
    #1;
    if (!hold) begin
      valid[s] = 1'b0;
      din[s]   = W'($urandom);
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (hold) din[s] = (k == last) ? nxt : W'($urandom);
      if (k <= 2 * d * int'(W)) begin
        j  = (k - 1) / (2 * d);
        hi = ((k - 1) % (2 * d)) >= d;
        e  = {hi, f[int'(W) - 1 - j], 1'b0, 1'b0, 1'b1};
      end else if (k <= 2 * d * int'(W) + d) begin
        e = {1'b0, f[0], 1'b1, 1'b0, 1'b1};
      end else begin
        e = {1'b0, f[0], 1'b0, 1'b1, 1'b0};
      end
      o = obs(s);
      check($sformatf("D%0d_f%h_cyc%0d", d, f, k), 32'(o), 32'(e));
      if (k > 1 && (o[4] === 1'b1 || o[2] === 1'b1))
        check($sformatf("ser_stable_D%0d_cyc%0d", d, k), 32'(o[3]), 32'(p[3]));
      check($sformatf("no_overlap_D%0d_cyc%0d", d, k), 32'(o[4] & o[2]), 32'd0);
      p = o;
      if (k == abort_at) begin
        rst_n[s] = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs(s)), 32'b00010);
        return;
      end
    end
  endtask

  logic [W-1:0] f;
  int           base_r;
  int           base_o;
  int           gap;
  int           s;

  initial begin
    rst_n    = 2'b00;
    valid    = 2'b00;
    din[0]   = '0;
    din[1]   = '0;

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid  = 2'($urandom);
      din[0] = W'($urandom);
      din[1] = W'($urandom);
      #1;
      check($sformatf("reset_s0_%0d", i), 32'(obs(0)), 32'b00010);
      check($sformatf("reset_s1_%0d", i), 32'(obs(1)), 32'b00010);
    end
    @(negedge clk);
    valid = 2'b00;
    rst_n = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("idle_s0_%0d", i), 32'(obs(0)), 32'b00010);
      check($sformatf("idle_s1_%0d", i), 32'(obs(1)), 32'b00010);
    end

    // Single frame, D=1.
    base_r = rises[0];
    frame(0, 16'hA5C3, 1'b0, '0, 0);
    check("disp_A5C3", 32'(disp[0]), 32'h0000A5C3);
    check("rises_A5C3", 32'(rises[0] - base_r), 32'd16);

    // Divider D=3 with a single one in the last bit.
    base_r = rises[1];
    base_o = ones[1];
    frame(1, 16'h0001, 1'b0, '0, 0);
    check("disp_0001", 32'(disp[1]), 32'h00000001);
    check("rises_0001", 32'(rises[1] - base_r), 32'd16);
    check("ones_0001", 32'(ones[1] - base_o), 32'd1);

    // Backpressure: valid held, second frame accepted on the first idle cycle.
    frame(0, 16'h1234, 1'b1, 16'hFFFF, 0);
    check("disp_1234", 32'(disp[0]), 32'h00001234);
    frame(0, 16'hFFFF, 1'b0, '0, 0);
    check("disp_FFFF", 32'(disp[0]), 32'h0000FFFF);

    // Reset in cycle 10 of a frame: no latch, storage keeps FFFF.
    f = W'($urandom);
    frame(0, f, 1'b0, '0, 10);
    valid[0] = 1'b0;
    @(negedge clk);
    check("held_reset_outputs", 32'(obs(0)), 32'b00010);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle_%0d", i), 32'(obs(0)), 32'b00010);
    end
    check("disp_kept_after_reset", 32'(disp[0]), 32'h0000FFFF);
    f = W'($urandom);
    frame(0, f, 1'b0, '0, 0);
    check("disp_after_reset_frame", 32'(disp[0]), 32'(f));

    // Random frames on both instances with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      s   = (r % 3 == 2) ? 1 : 0;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check($sformatf("gap_idle_r%0d", r), 32'(obs(s)), {27'd0, 1'b0, sdo[s], 3'b010});
      end
      f = W'($urandom);
      frame(s, f, 1'b0, '0, 0);
      check($sformatf("disp_rand_r%0d", r), 32'(disp[s]), 32'(f));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
